pll_reset_sequencer: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 41 ++++
 rtl/bit_synchronizer.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// FAIL is only reachable when RETRY_LIMIT_EN is defined.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        REL_MEM,
        RUN,
        FAIL
    } state_t;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_PLL_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT      = 65536;
    localparam int DEF_STABLE_CYCLES     = 1024;
    localparam int DEF_MEM_TO_CPU_CYCLES = 8;
    localparam int DEF_MAX_RETRIES       = 4;

    localparam int RETRIES_W = 8;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Shared counter width, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b,
                                     input int c, input int d);
        int w;
        w = $clog2(max4(a, b, c, d));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
// All flops clear to 0 while rst is high.
module bit_synchronizer
    import pll_rst_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor releasing mem then cpu resets.
// Optional macro RETRY_LIMIT_EN adds a terminal FAIL state.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES    = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES     = DEF_STABLE_CYCLES,
    parameter int MEM_TO_CPU_CYCLES = DEF_MEM_TO_CPU_CYCLES,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 locked,
    output logic                 pll_rst,
    output logic                 mem_rst,
    output logic                 cpu_rst,
    output logic                 ready,
    output logic [RETRIES_W-1:0] retries,
    output logic                 fail
);

    localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                  PLL_RST_CYCLES, MEM_TO_CPU_CYCLES);

    localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] M2C_LAST = CW'(MEM_TO_CPU_CYCLES - 1);

`ifdef RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t                 state;
    state_t                 state_n;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_n;
    logic [RETRIES_W-1:0]   retries_n;
    logic [RETRIES_W-1:0]   retries_inc;
    logic                   locked_s;
    logic                   at_limit;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    assign retries_inc = (retries == {RETRIES_W{1'b1}})
                       ? retries : retries + 1'b1;

    // This timeout would bring the retry count up to the limit.
    assign at_limit = (int'(retries) + 1) >= MAX_RETRIES;

    // Next-state, shared counter and retry count.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        retries_n = retries;
        unique case (state)
            PLL_RST: begin
                if (cnt == PLL_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                end else if (cnt == TMO_LAST) begin
                    retries_n = retries_inc;
                    state_n   = (LIMIT_EN && at_limit) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s) state_n = WAIT_LOCK;
                else if (cnt == STB_LAST) state_n = REL_MEM;
            end
            REL_MEM: begin
                if (!locked_s) state_n = WAIT_LOCK;
                else if (cnt == M2C_LAST) state_n = RUN;
            end
            RUN: begin
                cnt_n = cnt;
                if (!locked_s) state_n = WAIT_LOCK;
            end
            FAIL: begin
                cnt_n = cnt;
            end
            default: begin
                state_n = PLL_RST;
            end
        endcase
        if (state_n != state) cnt_n = '0;
    end

    // State, counter and registered outputs decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PLL_RST;
            cnt     <= '0;
            retries <= '0;
            pll_rst <= 1'b1;
            mem_rst <= 1'b1;
            cpu_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            retries <= retries_n;
            pll_rst <= (state_n == PLL_RST) || (state_n == FAIL);
            mem_rst <= !((state_n == REL_MEM) || (state_n == RUN));
            cpu_rst <= (state_n != RUN);
            ready   <= (state_n == RUN);
        end
    end

`ifdef RETRY_LIMIT_EN
    logic fail_q;

    // Sticky failure flag, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state_n == FAIL);
        end
    end

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer.
// Expected latencies are queued at stimulus time, popped on output.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int PRC    = 4;
    localparam int TMO    = 32;
    localparam int STB    = 8;
    localparam int M2C    = 3;
    localparam int MAXR   = 2;

    // locked is driven between edges, adding one sampling edge.
    localparam int MEM_LAT = SYNC + STB + 1;

`ifdef RETRY_LIMIT_EN
    localparam int N_TMO = MAXR;
`else
    localparam int N_TMO = 3;
`endif

    localparam int S_PLL = 0;
    localparam int S_MEM = 1;
    localparam int S_CPU = 2;
    localparam int S_RDY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       mem_rst;
    logic       cpu_rst;
    logic       ready;
    logic [7:0] retries;
    logic       fail;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   viol   = 0;

    always #10 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (TMO),
        .STABLE_CYCLES     (STB),
        .MEM_TO_CPU_CYCLES (M2C),
        .MAX_RETRIES       (MAXR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .locked  (locked),
        .pll_rst (pll_rst),
        .mem_rst (mem_rst),
        .cpu_rst (cpu_rst),
        .ready   (ready),
        .retries (retries),
        .fail    (fail)
    );

    // Ordering invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if ((!cpu_rst && mem_rst) ||
            (ready != !cpu_rst) ||
            (pll_rst && !(mem_rst && cpu_rst)))
            viol++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input int got);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", got, -1);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            S_PLL:   return pll_rst;
            S_MEM:   return mem_rst;
            S_CPU:   return cpu_rst;
            default: return ready;
        endcase
    endfunction

    // Negedges until output w equals v; budget+1 on timeout.
    task automatic wait_for(input int w, input logic v,
                            input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (sig(w) !== v && lat <= budget);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst    = 1'b1;
        locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat;

        repeat (2) @(negedge clk);
        push("rst_pll", 1);     observe(pll_rst);
        push("rst_mem", 1);     observe(mem_rst);
        push("rst_cpu", 1);     observe(cpu_rst);
        push("rst_ready", 0);   observe(ready);
        push("rst_retries", 0); observe(retries);
        push("rst_fail", 0);    observe(fail);

        // Nominal bring-up.
        rst = 1'b0;
        push("s1_pll_lo", PRC);
        wait_for(S_PLL, 1'b0, 20, lat); observe(lat);
        repeat (10 - PRC) @(negedge clk);
        locked = 1'b1;
        push("s1_mem_lat", MEM_LAT);
        wait_for(S_MEM, 1'b0, 40, lat); observe(lat);
        push("s1_cpu_lat", M2C);
        wait_for(S_CPU, 1'b0, 20, lat); observe(lat);
        push("s1_ready", 1);   observe(ready);
        push("s1_retries", 0); observe(retries);

        // Glitch while counting stability.
        rst_pulse();
        push("s2_pll_lo", PRC);
        wait_for(S_PLL, 1'b0, 20, lat); observe(lat);
        locked = 1'b1;
        repeat (5) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        push("s2_mem_held", 1); observe(mem_rst);
        push("s2_mem_lat", MEM_LAT);
        wait_for(S_MEM, 1'b0, 40, lat); observe(lat);
        push("s2_retries", 0); observe(retries);

        // Lock loss in RUN, then relock.
        push("s4_cpu_lat", M2C);
        wait_for(S_CPU, 1'b0, 20, lat); observe(lat);
        locked = 1'b0;
        push("s4_mem_hi", SYNC + 1);
        wait_for(S_MEM, 1'b1, 10, lat); observe(lat);
        push("s4_cpu_hi", 1);   observe(cpu_rst);
        push("s4_ready_lo", 0); observe(ready);
        push("s4_pll_lo", 0);   observe(pll_rst);
        locked = 1'b1;
        push("s4_ready_lat", MEM_LAT + M2C);
        wait_for(S_RDY, 1'b1, 60, lat); observe(lat);
        push("s4_pll_still_lo", 0); observe(pll_rst);
        push("s4_retries", 0);      observe(retries);

        // Lock timeout and PLL retry.
        rst_pulse();
        push("s3_pll_lo0", PRC);
        wait_for(S_PLL, 1'b0, 20, lat); observe(lat);
        for (int k = 1; k <= N_TMO; k++) begin
            push("s3_pll_hi", TMO);
            wait_for(S_PLL, 1'b1, TMO + 10, lat); observe(lat);
            push("s3_retries", k); observe(retries);
`ifdef RETRY_LIMIT_EN
            if (k == MAXR) begin
                push("s3_fail", 1); observe(fail);
                repeat (TMO + PRC + 4) @(negedge clk);
                push("s3_pll_held", 1); observe(pll_rst);
                break;
            end
`endif
            push("s3_pll_lo", PRC);
            wait_for(S_PLL, 1'b0, 20, lat); observe(lat);
        end

`ifdef RETRY_LIMIT_EN
        rst_pulse();
        wait_for(S_PLL, 1'b0, 20, lat);
        wait_for(S_PLL, 1'b1, TMO + 10, lat);
        wait_for(S_PLL, 1'b0, 20, lat);
`endif

        // Asynchronous reset while in REL_MEM.
        push("s5_retries_pre", (N_TMO == MAXR) ? 1 : N_TMO);
        observe(retries);
        locked = 1'b1;
        push("s5_mem_lat", MEM_LAT);
        wait_for(S_MEM, 1'b0, 40, lat); observe(lat);
        #3 rst = 1'b1;
        #1;
        push("s5_pll", 1);     observe(pll_rst);
        push("s5_mem", 1);     observe(mem_rst);
        push("s5_cpu", 1);     observe(cpu_rst);
        push("s5_ready", 0);   observe(ready);
        push("s5_retries", 0); observe(retries);
        push("s5_fail", 0);    observe(fail);
        @(negedge clk);
        rst = 1'b0;
        push("s5_restart_pll_lo", PRC);
        wait_for(S_PLL, 1'b0, 20, lat); observe(lat);

        // Random lock activity for the invariant monitor.
`ifdef RETRY_LIMIT_EN
        rst_pulse();
`endif
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) locked = ~locked;
        end
        @(negedge clk);
        push("invariants", 0); observe(viol);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
